// File: rtl/sccb_cfg_sequencer.sv
// sccb_cfg_sequencer: walks a register table ROM and hands each {reg, val}
// entry to an SCCB byte writer, with timed delay entries and an end marker.
// Entry words: 0xFFFF ends the pass, 0xFFF0 waits DELAY_CYC cycles, anything
// else is a register write.
// Optional feature: define SCCB_CFG_RETRY_EN to retry a nacked write up to
// three times before the pass aborts; without it the first nack aborts.
// Writer handshake: wr_req rises with wr_addr/wr_data already registered and
// stays high, with both held stable, until wr_ack or wr_nack is sampled;
// wr_req drops on the following cycle. Responses outside WAIT_WR are ignored.
module sccb_cfg_sequencer #(
    parameter int TABLE_LEN = 64,
    parameter int DELAY_CYC = 250000
) (
    input  logic        clk25,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    output logic        wr_req,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_ack,
    input  logic        wr_nack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_WAIT_WR = 3'd4,
        ST_DELAY   = 3'd5,
        ST_FINISH  = 3'd6,
        ST_FAIL    = 3'd7
    } state_t;

    localparam logic [15:0] END_WORD   = 16'hFFFF;
    localparam logic [15:0] DELAY_WORD = 16'hFFF0;
    localparam logic [8:0]  LAST_CNT   = 9'(TABLE_LEN);
    localparam logic [19:0] DLY_LOAD   = 20'(DELAY_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  tbl_addr_q, tbl_addr_d;
    logic        wr_req_q, wr_req_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [19:0] dly_q, dly_d;
`ifdef SCCB_CFG_RETRY_EN
    logic [1:0]  retry_q, retry_d;
`endif

    // Count of entries consumed if the current one completes; 9 bits so that
    // TABLE_LEN = 256 compares without the address wrapping to 0.
    logic [8:0] next_cnt;
    logic       advance;

    assign next_cnt = {1'b0, tbl_addr_q} + 9'd1;

    // Next-state and datapath: every _d defaults to hold, cases override.
    always_comb begin
        state_d    = state_q;
        tbl_addr_d = tbl_addr_q;
        wr_req_d   = wr_req_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        dly_d      = dly_q;
`ifdef SCCB_CFG_RETRY_EN
        retry_d    = retry_q;
`endif
        advance    = 1'b0;

        case (state_q)
            ST_IDLE, ST_FINISH, ST_FAIL: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    tbl_addr_d = 8'd0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end
            end
            ST_FETCH: begin
                // ROM word for tbl_addr appears after this cycle.
                state_d = ST_DECODE;
`ifdef SCCB_CFG_RETRY_EN
                retry_d = 2'd0;
`endif
            end
            ST_DECODE: begin
                if (tbl_data == END_WORD) begin
                    state_d = ST_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (tbl_data == DELAY_WORD) begin
                    state_d = ST_DELAY;
                    dly_d   = DLY_LOAD;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // tbl_addr is unchanged, so tbl_data still holds this entry
                // (also on a retry).
                wr_addr_d = tbl_data[15:8];
                wr_data_d = tbl_data[7:0];
                wr_req_d  = 1'b1;
                state_d   = ST_WAIT_WR;
            end
            ST_WAIT_WR: begin
                // A nack wins over a simultaneous ack.
                if (wr_nack) begin
                    wr_req_d = 1'b0;
`ifdef SCCB_CFG_RETRY_EN
                    if (retry_q != 2'd3) begin
                        retry_d = retry_q + 2'd1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_FAIL;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end
`else
                    state_d = ST_FAIL;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
`endif
                end else if (wr_ack) begin
                    wr_req_d = 1'b0;
                    advance  = 1'b1;
                end
            end
            ST_DELAY: begin
                if (dly_q == 20'd0) begin
                    advance = 1'b1;
                end else begin
                    dly_d = dly_q - 20'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Move to the next entry, or finish once TABLE_LEN entries are used.
        if (advance) begin
            if (next_cnt == LAST_CNT) begin
                state_d = ST_FINISH;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                tbl_addr_d = next_cnt[7:0];
                state_d    = ST_FETCH;
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tbl_addr_q <= 8'd0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            dly_q      <= 20'd0;
`ifdef SCCB_CFG_RETRY_EN
            retry_q    <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            tbl_addr_q <= tbl_addr_d;
            wr_req_q   <= wr_req_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            dly_q      <= dly_d;
`ifdef SCCB_CFG_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign tbl_addr  = tbl_addr_q;
    assign wr_req    = wr_req_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule
